// File: rtl/adc_sample_avg.sv
// Paces ADC conversion requests, boxcar-averages 2^AVG_LOG2 ch0/ch1 pairs and
// presents them on a valid/ready output. Define ADC_OFFSET_BINARY_EN for offset-binary outputs.
module adc_sample_avg #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned RATE_DIV = 100,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_flags,
  output logic             conv,
  input  logic             end_conv,
  input  logic [WIDTH-1:0] ch0_in,
  input  logic [WIDTH-1:0] ch1_in,
  output logic [WIDTH-1:0] ch0_avg,
  output logic [WIDTH-1:0] ch1_avg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             timeout
);

  localparam int unsigned ACC_W  = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned RATE_W = $clog2(RATE_DIV);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [RATE_W-1:0] RATE_RELOAD = RATE_W'(RATE_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(1 << AVG_LOG2);

`ifdef ADC_OFFSET_BINARY_EN
  localparam logic [WIDTH-1:0] OUT_FLIP = WIDTH'(1) << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] OUT_FLIP = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_ACC} state_e;

  state_e                   state_q, state_d;
  logic [RATE_W-1:0]        rate_q, rate_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic [WIDTH-1:0]         avg0_q, avg0_d, avg1_q, avg1_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_q, timeout_d;
  logic                     expire, load, tmo_set;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    expire  = enable && (rate_q == '0);
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (expire) state_d = S_TRIG;
      S_TRIG:  state_d = S_WAIT;
      S_WAIT: begin
        if (end_conv)                state_d = S_ACC;
        else if (wait_q == WAIT_LAST) state_d = S_IDLE;
      end
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rate_d  = rate_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    load    = 1'b0;
    tmo_set = 1'b0;

    if (!enable || rate_q == '0) rate_d = RATE_RELOAD;
    else                         rate_d = rate_q - RATE_W'(1);

    case (state_q)
      S_TRIG: wait_d = '0;
      S_WAIT: begin
        if (end_conv) begin
          acc0_d = acc0_q + ACC_W'(signed'(ch0_in));
          acc1_d = acc1_q + ACC_W'(signed'(ch1_in));
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
          tmo_set = (wait_q == WAIT_LAST);
        end
      end
      S_ACC: begin
        if (cnt_q == CNT_FULL) begin
          load   = 1'b1;
          acc0_d = '0;
          acc1_d = '0;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase

    // Dropping the low AVG_LOG2 bits of the signed sum is the floor division.
    avg0_d    = load ? (acc0_q[ACC_W-1:AVG_LOG2] ^ OUT_FLIP) : avg0_q;
    avg1_d    = load ? (acc1_q[ACC_W-1:AVG_LOG2] ^ OUT_FLIP) : avg1_q;
    valid_d   = load | (valid_q & ~out_ready);
    overrun_d = (load & valid_q & ~out_ready) | (overrun_q & ~clear_flags);
    timeout_d = tmo_set | (timeout_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q    <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      acc0_q    <= '0;
      acc1_q    <= '0;
      avg0_q    <= '0;
      avg1_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      avg0_q    <= avg0_d;
      avg1_q    <= avg1_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    conv      = (state_q == S_TRIG);
    ch0_avg   = avg0_q;
    ch1_avg   = avg1_q;
    out_valid = valid_q;
    overrun   = overrun_q;
    timeout   = timeout_q;
  end

endmodule
